// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with 3-sample majority voting.
// Emits one byte plus a one-cycle done strobe, or a frame error strobe.
`timescale 1ns/1ps
module uart_byte_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       uart_rx_done,
  output logic [7:0] uart_rx_data,
  output logic       uart_frame_err,
  output logic       uart_busy
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int MID      = BAUD_CNT / 2;
  localparam int CW       = $clog2(BAUD_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] CNT_M1   = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_DEC  = CW'(MID + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (BAUD_CNT < 8) begin : g_bad_baud
    $error("uart_byte_rx: BAUD_CNT must be at least 8");
  end

  logic          rx_s1_q, rx_s2_q, rx_s3_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    samp_q, samp_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;

  logic fall, cnt_last, at_dec, maj;

  // Line synchronizer plus edge-detect stage; idle line reads high.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= uart_rxd;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  // Frame FSM: baud timing, majority sampling, shift and output strobes.
  always_comb begin
    fall      = rx_s3_q & ~rx_s2_q;
    cnt_last  = (cnt_q == CNT_LAST);
    at_dec    = (cnt_q == CNT_DEC);
    maj       = (samp_q[0] & samp_q[1]) |
                (samp_q[0] & rx_s2_q) |
                (samp_q[1] & rx_s2_q);
    state_d   = state_q;
    cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    if (cnt_q == CNT_M1) samp_d[0] = rx_s2_q;
    if (cnt_q == CNT_MID) samp_d[1] = rx_s2_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (at_dec && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (at_dec) shift_d = {maj, shift_q[7:1]};
        if (cnt_last) begin
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (at_dec) begin
          if (maj) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame state registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      samp_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  assign uart_rx_done   = done_q;
  assign uart_rx_data   = data_q;
  assign uart_frame_err = ferr_q;
  assign uart_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: drives 8N1 frames cycle by cycle and checks the
// received bytes, strobes and timing against expected values.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int CP  = 20;
  localparam int BC  = 434;
  localparam int MID = 217;
  localparam int LAT = 9 * BC + MID + 4;

  logic       clk_50m = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_done;
  logic [7:0] uart_rx_data;
  logic       uart_frame_err;
  logic       uart_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  time        t_q[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         dbl_cnt = 0;
  logic       prev_done = 1'b0;
  time        t_fall;
  logic [7:0] last_good = 8'h00;

  always #(CP / 2) clk_50m = ~clk_50m;

  uart_byte_rx #(
    .CLK_FREQ (50_000_000),
    .BAUD_RATE(115200)
  ) dut (
    .clk_50m       (clk_50m),
    .rst_n         (rst_n),
    .uart_rxd      (uart_rxd),
    .uart_rx_done  (uart_rx_done),
    .uart_rx_data  (uart_rx_data),
    .uart_frame_err(uart_frame_err),
    .uart_busy     (uart_busy)
  );

  always @(negedge clk_50m) begin
    if (uart_rx_done) begin
      rx_q.push_back(uart_rx_data);
      t_q.push_back($time);
    end
    if (uart_frame_err) ferr_cnt++;
    if (uart_rx_done && uart_frame_err) both_cnt++;
    if (uart_rx_done && prev_done) dbl_cnt++;
    prev_done = uart_rx_done;
  end

  initial begin
    #(CP * 90000);
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic clear_mon();
    rx_q.delete();
    t_q.delete();
    ferr_cnt = 0;
    both_cnt = 0;
    dbl_cnt  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  // One pin level per clock; ncyc < 0 drives the full 10-bit frame.
  task automatic send_frame(input logic [7:0] d, input int p,
                            input logic stop, input int spike,
                            input int ncyc);
    logic [9:0] fr;
    int total;
    int b;
    fr    = {stop, d, 1'b0};
    total = (ncyc < 0) ? 10 * p : ncyc;
    for (int j = 0; j < total; j++) begin
      @(negedge clk_50m);
      if (j == 0) t_fall = $time;
      b = j / p;
      uart_rxd = (j == spike) ? 1'b0 : fr[b];
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(5);
    checks++;
    if ({uart_rx_done, uart_frame_err, uart_busy, uart_rx_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %0h want 0",
               {uart_rx_done, uart_frame_err, uart_busy, uart_rx_data});
    end
    rst_n = 1'b1;
    idle(20);
  endtask

  task automatic test_single();
    int lat;
    clear_mon();
    send_frame(8'h99, BC, 1'b1, -1, -1);
    idle(50);
    checks++;
    if (rx_q.size() !== 1) begin
      errors++;
      $display("FAIL single_count got %0d want 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== 8'h99) begin
        errors++;
        $display("FAIL single_data got %0h want 99", rx_q[0]);
      end
      lat = int'((t_q[0] - t_fall) / CP) - 1;
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        errors++;
        $display("FAIL single_latency got %0d want %0d", lat, LAT);
      end
    end
    checks++;
    if (ferr_cnt !== 0 || dbl_cnt !== 0) begin
      errors++;
      $display("FAIL single_strobes got ferr=%0d dbl=%0d want 0 0",
               ferr_cnt, dbl_cnt);
    end
    last_good = 8'h99;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int gap;
    clear_mon();
    exp_q = '{8'h99, 8'h50, 8'hA5};
    foreach (exp_q[i]) send_frame(exp_q[i], BC, 1'b1, -1, -1);
    idle(100);
    checks++;
    if (rx_q.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", rx_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_data%0d got %0h want %0h", i, rx_q[i], exp_q[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        gap = int'((t_q[i] - t_q[i-1]) / CP);
        checks++;
        if (gap < 10 * BC - 2 || gap > 10 * BC + 2) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d want %0d", i, gap, 10 * BC);
        end
      end
      last_good = 8'hA5;
    end
    checks++;
    if (ferr_cnt !== 0 || both_cnt !== 0 || dbl_cnt !== 0) begin
      errors++;
      $display("FAIL b2b_strobes got ferr=%0d both=%0d dbl=%0d want 0",
               ferr_cnt, both_cnt, dbl_cnt);
    end
  endtask

  task automatic test_glitch();
    logic b10, b200, b240;
    b10 = 1'b0;
    b200 = 1'b0;
    b240 = 1'b1;
    clear_mon();
    for (int j = 0; j < 300; j++) begin
      @(negedge clk_50m);
      uart_rxd = (j < 100) ? 1'b0 : 1'b1;
      if (j == 10) b10 = uart_busy;
      if (j == 200) b200 = uart_busy;
      if (j == 240) b240 = uart_busy;
    end
    chk("glitch_busy_early", int'({b10, b200}), 3);
    chk("glitch_busy_late", int'(b240), 0);
    chk("glitch_no_strobe", rx_q.size() + ferr_cnt, 0);
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'h3C, BC, 1'b0, -1, -1);
    idle(3 * BC);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_no_done", rx_q.size(), 0);
    chk("ferr_data_held", int'(uart_rx_data), int'(last_good));
    chk("ferr_break_idle", int'(uart_busy), 0);
    uart_rxd = 1'b1;
    idle(BC);
    send_frame(8'h11, BC, 1'b1, -1, -1);
    idle(50);
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h11) begin
      errors++;
      $display("FAIL ferr_recover got n=%0d d=%0h want n=1 d=11",
               rx_q.size(), uart_rx_data);
    end
    chk("ferr_recover_err", ferr_cnt + both_cnt, 1);
    last_good = 8'h11;
  endtask

  task automatic test_spike();
    clear_mon();
    send_frame(8'hFF, BC, 1'b1, 1 + 4 * BC + MID, -1);
    idle(50);
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'hFF) begin
      errors++;
      $display("FAIL spike_data got n=%0d d=%0h want n=1 d=ff",
               rx_q.size(), uart_rx_data);
    end
    last_good = 8'hFF;
  endtask

  task automatic test_baud_tolerance();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int p;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(1, 255));
      p = (i % 2 == 0) ? 421 : 447;
      if (i == 3) p = $urandom_range(421, 447);
      exp_q.push_back(d);
      send_frame(d, p, 1'b1, -1, -1);
      idle($urandom_range(0, 30));
    end
    idle(50);
    chk("tol_count", rx_q.size(), exp_q.size());
    if (rx_q.size() == exp_q.size()) begin
      foreach (exp_q[i]) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL tol_data%0d got %0h want %0h", i, rx_q[i], exp_q[i]);
        end
      end
    end
    chk("tol_ferr", ferr_cnt, 0);
    last_good = exp_q[$];
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_frame(8'h5A, BC, 1'b1, -1, 5 * BC + 200);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({uart_rx_done, uart_frame_err, uart_busy, uart_rx_data} !== 11'd0) begin
      errors++;
      $display("FAIL midrst_outputs got %0h want 0 (prev data %0h)",
               {uart_rx_done, uart_frame_err, uart_busy, uart_rx_data},
               last_good);
    end
    uart_rxd = 1'b1;
    idle(10);
    rst_n = 1'b1;
    idle(2 * BC);
    chk("midrst_no_strobe", rx_q.size() + ferr_cnt, 0);
    send_frame(8'h5A, BC, 1'b1, -1, -1);
    idle(50);
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A || dbl_cnt !== 0) begin
      errors++;
      $display("FAIL midrst_recover got n=%0d d=%0h dbl=%0d want n=1 d=5a",
               rx_q.size(), uart_rx_data, dbl_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_spike();
    test_baud_tolerance();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- UART byte receiver: 8N1 serial line in, one parallel byte plus a one-cycle valid strobe out.
- Sits directly upstream of the frame parser that matches header bytes (0x99, 0x50) and assembles payload words.
- Its `uart_rx_done` / `uart_rx_data` pair is exactly what that parser consumes: strobe qualifies data on the same cycle.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in baud.
- BAUD_CNT (localparam), CLK_FREQ/BAUD_RATE (integer division; 434 at defaults), clocks per bit. Elaboration error if < 8.
- MID (localparam), BAUD_CNT/2 (217 at defaults), sample point within a bit.

Ports:
- clk_50m  input  1  system clock.
- rst_n  input  1  reset.
- uart_rxd  input  1  asynchronous serial line, idle high.
- uart_rx_done  output  1  one-cycle strobe: a valid byte is on uart_rx_data.
- uart_rx_data  output  8  last correctly received byte, LSB first on the line.
- uart_frame_err  output  1  one-cycle strobe: stop bit sampled low.
- uart_busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset (already decided): reset rst_n, asynchronous, active-low; clock clk_50m.
- Reset values:
  - uart_rx_done=0, uart_frame_err=0, uart_rx_data=8'h00, uart_busy=0, state=IDLE.
  - Synchronizer flops reset to 1.
  - Bit counter, baud counter and shift register reset to 0.
- Input conditioning:
  - 2-flop synchronizer on uart_rxd, then a third flop for edge detection.
  - Falling edge = previous synchronized value 1, current 0.
- Baud counter:
  - Counts 0..BAUD_CNT-1 and wraps to 0 at BAUD_CNT-1.
  - Cleared on entry to START.
- Bit sampling:
  - Synchronized line sampled at cnt = MID-1, MID and MID+1.
  - Bit value = 2-of-3 majority, decided at cnt = MID+1.
- FSM:
  - IDLE: on falling edge -> START, cnt=0.
  - START:
    - At decision point, majority=1 -> IDLE (glitch rejected, no strobe).
    - Else stay until cnt = BAUD_CNT-1 -> DATA, bit_idx=0.
  - DATA:
    - At decision point, shift majority into shift register, LSB first.
    - At cnt = BAUD_CNT-1: bit_idx increments; after bit_idx=7 -> STOP.
  - STOP, at decision point:
    - Majority=1: uart_rx_data <= shift register; uart_rx_done=1 for exactly one cycle (same cycle data is updated); -> IDLE.
    - Majority=0: uart_frame_err=1 for one cycle; uart_rx_data unchanged; -> IDLE.
- Early return: IDLE is re-entered at mid stop bit, so a start bit immediately after the stop bit is caught.
- Break condition: a line held low after a framing error produces no new frame until the line returns high and falls again.
- uart_rx_done and uart_frame_err are never high in the same cycle.
- uart_rx_data holds its value until the next valid byte.
- Latency: uart_rx_done rises 9*BAUD_CNT + MID + 4 cycles (±1) after the uart_rxd pin falling edge; 4127 ±1 at defaults.
- Baud tolerance: frames with bit period within ±3% of nominal are received correctly.
- Reset mid-frame: all outputs go to reset values immediately. The partial frame is discarded with no strobe. The next complete frame after release is received normally.
- uart_busy is combinational from state; no other outputs are combinational.

Test Plan:
- Send 0x99 at 115200 baud, one stop bit -> uart_rx_data=8'h99, uart_rx_done high exactly 1 cycle, 4127 ±1 cycles after start edge; uart_frame_err stays 0.
- Back-to-back 0x99, 0x50, 0xA5 with zero idle between frames -> three done strobes about 4340 cycles apart; data 0x99, 0x50, 0xA5 in order.
- Low glitch of 100 cycles on idle line -> no done, no frame_err; uart_busy high then low about 219 cycles after the edge.
- Frame 0x3C with stop bit forced 0 -> uart_frame_err 1-cycle pulse, no done, uart_rx_data keeps previous value. Then line high 1 bit time, send 0x11 -> received correctly.
- Frame 0xFF with a 1-cycle low spike at cnt=MID in bit 3 -> majority rejects it, data=8'hFF. Repeat all bytes with bit period 421 and 447 clocks (±3%) -> correct data.
- Assert rst_n low during data bit 4 of 0x5A -> outputs reset immediately, no strobe. After release, send 0x5A -> uart_rx_data=8'h5A, one done pulse.
